// File: rtl/regfile_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: request kinds, FSM states,
// request/control structs and the kind-to-control encoder.
package regfile_write_sequencer_pkg;

  localparam int W          = 8;
  localparam int D          = 4;
  localparam int FIFO_DEPTH = 2;

  localparam logic [D-1:0] OPS_REG  = 4'd13;
  localparam logic [D-1:0] FLAG_REG = 4'd12;

  typedef enum logic [2:0] {
    KIND_ALU  = 3'd0,
    KIND_MOV  = 3'd1,
    KIND_LDB  = 3'd2,
    KIND_OPSH = 3'd3,
    KIND_OPSL = 3'd4,
    KIND_OPS8 = 3'd5,
    KIND_NOP  = 3'd6,
    KIND_ILL  = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_OPS_LO = 2'd2
  } state_e;

  typedef struct packed {
    kind_e          kind;
    logic [D-1:0]   addr;
    logic [W-1:0]   data;
    logic           ovf;
  } req_t;

  typedef struct packed {
    logic           ops_write;
    logic           load_high;
    logic           jmp;
    logic           is_mov;
    logic           load_byte;
    logic           overflow;
    logic [D-1:0]   waddr;
    logic [W-1:0]   data_in;
  } wr_ctrl_t;

  // jmp doubles as the register file's write inhibit, so "nothing issuing" means jmp=1.
  function automatic wr_ctrl_t idle_ctrl();
    wr_ctrl_t c;
    c     = '0;
    c.jmp = 1'b1;
    return c;
  endfunction

  function automatic wr_ctrl_t ops_ctrl(input logic high, input logic [3:0] nib);
    wr_ctrl_t c;
    c           = '0;
    c.ops_write = 1'b1;
    c.load_high = high;
    c.data_in   = {4'b0000, nib};
    return c;
  endfunction

  // OPS8 encodes only its high half here; the low half is issued from the OPS_LO state.
  function automatic wr_ctrl_t encode_req(input req_t r);
    wr_ctrl_t c;
    c     = '0;
    case (r.kind)
      KIND_ALU: begin
        c.waddr    = r.addr;
        c.data_in  = r.data;
        c.overflow = r.ovf;
      end
      KIND_MOV: begin
        c.is_mov  = 1'b1;
        c.data_in = r.data;
      end
      KIND_LDB: begin
        c.load_byte = 1'b1;
        c.data_in   = r.data;
      end
      KIND_OPSH: c = ops_ctrl(1'b1, r.data[3:0]);
      KIND_OPSL: c = ops_ctrl(1'b0, r.data[3:0]);
      KIND_OPS8: c = ops_ctrl(1'b1, r.data[7:4]);
      default:   c = idle_ctrl();
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_fifo.sv
// wb_req_fifo: small synchronous request FIFO with power-of-two depth and full/empty flags.
// Pushing and popping together on an empty FIFO passes the entry straight through.
module wb_req_fifo
  import regfile_write_sequencer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (!empty || push_ok);
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
    if (push_ok && !reset) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register-file write-port master: queues writeback requests and issues them in order,
// one write per cycle, splitting full-byte ops loads into high then low nibble writes.
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int DEPTH = regfile_write_sequencer_pkg::FIFO_DEPTH
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [2:0]   ReqKind,
  input  logic [D-1:0] ReqAddr,
  input  logic [W-1:0] ReqData,
  input  logic         ReqOvf,
  output logic         opsWrite,
  output logic         loadHigh,
  output logic         jmp,
  output logic         isMov,
  output logic         loadByte,
  output logic         OverFlow,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         Busy,
  output logic         Err
);

  state_e    state_q, state_d;
  wr_ctrl_t  ctrl_q, ctrl_d;
  logic [3:0] lo_nib_q, lo_nib_d;
  logic      err_q, err_d;

  req_t      in_req, fifo_head, head;
  logic      push, pop, fifo_full, fifo_empty, head_avail;

  assign in_req   = '{kind: kind_e'(ReqKind), addr: ReqAddr, data: ReqData, ovf: ReqOvf};
  assign ReqReady = !fifo_full;
  assign push     = ReqValid && ReqReady;

  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (push),
    .wdata (in_req),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An empty FIFO forwards the incoming request so an accepted write issues the next cycle.
  assign head       = fifo_empty ? in_req : fifo_head;
  assign head_avail = !fifo_empty || push;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = idle_ctrl();
    lo_nib_d = lo_nib_q;
    err_d    = err_q;
    pop      = 1'b0;
    case (state_q)
      ST_OPS_LO: begin
        ctrl_d  = ops_ctrl(1'b0, lo_nib_q);
        state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: begin
        if (head_avail) begin
          pop     = 1'b1;
          ctrl_d  = encode_req(head);
          state_d = ST_ISSUE;
          if (head.kind == KIND_OPS8) begin
            state_d  = ST_OPS_LO;
            lo_nib_d = head.data[3:0];
          end
          if (head.kind == KIND_ILL) err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // A reset during OPS8 drops the pending low nibble along with the queued requests.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= idle_ctrl();
      lo_nib_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      lo_nib_q <= lo_nib_d;
      err_q    <= err_d;
    end
  end

  assign opsWrite = ctrl_q.ops_write;
  assign loadHigh = ctrl_q.load_high;
  assign jmp      = ctrl_q.jmp;
  assign isMov    = ctrl_q.is_mov;
  assign loadByte = ctrl_q.load_byte;
  assign OverFlow = ctrl_q.overflow;
  assign Waddr    = ctrl_q.waddr;
  assign DataIn   = ctrl_q.data_in;
  assign Busy     = !fifo_empty || (state_q == ST_OPS_LO);
  assign Err      = err_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer: directed requests push hand-computed
// expected writes; a negedge monitor checks every issued write and every idle cycle.
module tb_regfile_write_sequencer;
  import regfile_write_sequencer_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqKind;
  logic [3:0]  ReqAddr;
  logic [7:0]  ReqData;
  logic        ReqOvf;
  logic        opsWrite, loadHigh, jmp, isMov, loadByte, OverFlow;
  logic [3:0]  Waddr;
  logic [7:0]  DataIn;
  logic        Busy, Err;

  typedef struct {
    string       name;
    logic [16:0] val;
  } expWrite_t;

  expWrite_t   expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          stallCount = 0;
  logic [16:0] gotVec;

  assign gotVec = {opsWrite, loadHigh, isMov, loadByte, OverFlow, Waddr, DataIn};

  regfile_write_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqKind  (ReqKind),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .ReqOvf   (ReqOvf),
    .opsWrite (opsWrite),
    .loadHigh (loadHigh),
    .jmp      (jmp),
    .isMov    (isMov),
    .loadByte (loadByte),
    .OverFlow (OverFlow),
    .Waddr    (Waddr),
    .DataIn   (DataIn),
    .Busy     (Busy),
    .Err      (Err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [16:0] mk(input logic ops, input logic lh, input logic mov,
                                     input logic ldb, input logic ovf,
                                     input logic [3:0] a, input logic [7:0] d);
    return {ops, lh, mov, ldb, ovf, a, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input string name, input logic [16:0] val);
    expWrite_t e;
    e.name = name;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // Holds the request until it is accepted; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [2:0] kind, input logic [3:0] addr,
                               input logic [7:0] data, input logic ovf);
    logic rdy;
    logic accepted;
    ReqValid = 1'b1;
    ReqKind  = kind;
    ReqAddr  = addr;
    ReqData  = data;
    ReqOvf   = ovf;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge Clk);
      rdy = ReqReady;
      if (!rdy) stallCount++;
      @(posedge Clk);
      accepted = rdy;
    end
    #1;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: got ReqReady stuck low expected acceptance");
    end
  endtask

  task automatic idleInputs();
    ReqValid = 1'b0;
    ReqKind  = KIND_NOP;
    ReqAddr  = '0;
    ReqData  = '0;
    ReqOvf   = 1'b0;
  endtask

  // Monitor: a real write (jmp=0) must match the oldest expectation; idle must be all zero.
  always @(negedge Clk) begin
    if (jmp === 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got %0h expected no write", gotVec);
      end else begin
        expWrite_t e;
        e = expQ.pop_front();
        checkOutput(e.name, 32'(gotVec), 32'(e.val));
      end
    end else if (jmp === 1'b1) begin
      checkOutput("idle_ctrl", 32'(gotVec), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    repeat (3) @(negedge Clk);
    checkOutput("reset_jmp", 32'(jmp), 32'd1);
    checkOutput("reset_ready", 32'(ReqReady), 32'd1);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_err", 32'(Err), 32'd0);

    // ALU accepted in cycle 0 must be on the write port in cycle 1.
    @(posedge Clk); #1;
    expectWrite("alu_write", mk(0, 0, 0, 0, 1, 4'd3, 8'h5A));
    applyStimulus(KIND_ALU, 4'd3, 8'h5A, 1'b1);
    idleInputs();
    @(negedge Clk);
    checkOutput("alu_latency_jmp", 32'(jmp), 32'd0);
    checkOutput("alu_latency_waddr", 32'(Waddr), 32'd3);

    // OPS8 0x47 then MOV 0x99 back to back.
    @(posedge Clk); #1;
    expectWrite("ops8_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h04));
    expectWrite("ops8_lo", mk(1, 0, 0, 0, 0, 4'd0, 8'h07));
    expectWrite("mov_after_ops8", mk(0, 0, 1, 0, 0, 4'd0, 8'h99));
    applyStimulus(KIND_OPS8, 4'd0, 8'h47, 1'b0);
    checkOutput("ops8_busy_hi", 32'(Busy), 32'd1);
    applyStimulus(KIND_MOV, 4'd0, 8'h99, 1'b0);
    idleInputs();
    @(negedge Clk);
    checkOutput("ops8_busy_lo", 32'(Busy), 32'd1);
    repeat (3) @(negedge Clk);
    checkOutput("ops8_busy_drained", 32'(Busy), 32'd0);

    // Remaining kinds, including a NOP that must produce no write.
    @(posedge Clk); #1;
    expectWrite("ldb_write", mk(0, 0, 0, 1, 0, 4'd0, 8'h3C));
    expectWrite("opsh_write", mk(1, 1, 0, 0, 0, 4'd0, 8'h0B));
    expectWrite("opsl_write", mk(1, 0, 0, 0, 0, 4'd0, 8'h0E));
    expectWrite("alu_flag_reg", mk(0, 0, 0, 0, 0, FLAG_REG, 8'h00));
    applyStimulus(KIND_LDB, 4'd7, 8'h3C, 1'b1);
    applyStimulus(KIND_OPSH, 4'd0, 8'hAB, 1'b0);
    applyStimulus(KIND_NOP, 4'd0, 8'hFF, 1'b0);
    applyStimulus(KIND_OPSL, 4'd0, 8'h5E, 1'b0);
    applyStimulus(KIND_ALU, FLAG_REG, 8'h00, 1'b0);
    idleInputs();
    repeat (4) @(negedge Clk);

    // Back-to-back OPS8s fill the two-entry FIFO; the fifth request must be held off.
    @(posedge Clk); #1;
    stallCount = 0;
    expectWrite("bp_a_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h01));
    expectWrite("bp_a_lo", mk(1, 0, 0, 0, 0, 4'd0, 8'h02));
    expectWrite("bp_b_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h03));
    expectWrite("bp_b_lo", mk(1, 0, 0, 0, 0, 4'd0, 8'h04));
    expectWrite("bp_c_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h05));
    expectWrite("bp_c_lo", mk(1, 0, 0, 0, 0, 4'd0, 8'h06));
    expectWrite("bp_d_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h07));
    expectWrite("bp_d_lo", mk(1, 0, 0, 0, 0, 4'd0, 8'h08));
    expectWrite("bp_e_alu", mk(0, 0, 0, 0, 0, 4'd9, 8'hE1));
    applyStimulus(KIND_OPS8, 4'd0, 8'h12, 1'b0);
    applyStimulus(KIND_OPS8, 4'd0, 8'h34, 1'b0);
    applyStimulus(KIND_OPS8, 4'd0, 8'h56, 1'b0);
    applyStimulus(KIND_OPS8, 4'd0, 8'h78, 1'b0);
    checkOutput("bp_not_stalled_yet", 32'(stallCount), 32'd0);
    applyStimulus(KIND_ALU, 4'd9, 8'hE1, 1'b0);
    idleInputs();
    checkOutput("bp_fifo_full_stall", 32'(stallCount > 0), 32'd1);
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge Clk);
    @(negedge Clk);
    checkOutput("bp_ready_after_drain", 32'(ReqReady), 32'd1);

    // Illegal kind: one idle cycle, sticky Err, later writes still issue.
    @(posedge Clk); #1;
    applyStimulus(KIND_ILL, 4'd2, 8'hFF, 1'b1);
    idleInputs();
    @(negedge Clk);
    checkOutput("ill_idle_jmp", 32'(jmp), 32'd1);
    checkOutput("ill_err_set", 32'(Err), 32'd1);
    @(posedge Clk); #1;
    expectWrite("alu_after_ill", mk(0, 0, 0, 0, 1, 4'd5, 8'h77));
    applyStimulus(KIND_ALU, 4'd5, 8'h77, 1'b1);
    idleInputs();
    repeat (4) @(negedge Clk);
    checkOutput("ill_err_sticky", 32'(Err), 32'd1);

    // Reset during the OPSH cycle of OPS8 0xC3 drops the low nibble and clears Err.
    @(posedge Clk); #1;
    expectWrite("rst_ops8_hi", mk(1, 1, 0, 0, 0, 4'd0, 8'h0C));
    ReqValid = 1'b1;
    ReqKind  = KIND_OPS8;
    ReqAddr  = '0;
    ReqData  = 8'hC3;
    ReqOvf   = 1'b0;
    @(negedge Clk);
    checkOutput("rst_ops8_ready", 32'(ReqReady), 32'd1);
    @(posedge Clk); #1;
    idleInputs();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_mid_jmp", 32'(jmp), 32'd1);
    checkOutput("rst_mid_busy", 32'(Busy), 32'd0);
    checkOutput("rst_mid_ready", 32'(ReqReady), 32'd1);
    checkOutput("rst_mid_err", 32'(Err), 32'd0);
    repeat (4) @(negedge Clk);

    for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge Clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
